// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared definitions for the IF/MEM memory port arbiter.
//   - arb_state_t : arbiter FSM encoding (IDLE / DATA / FETCH)
//   - DEF_AW, DEF_DW, DEF_TIMEOUT : default address/data width and ack timeout
//   - sat_inc32() : saturating increment used by the optional stall counters
package mem_arb_pkg;

    localparam int DEF_AW      = 32;
    localparam int DEF_DW      = 32;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } arb_state_t;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request/acknowledge bus between the arbiter and the
// single-port instruction/data memory.
//   mem_req   : access request, held until mem_ack
//   mem_we    : write enable, meaningful only while mem_req is high
//   mem_addr  : access address
//   mem_wdata : store data
//   mem_rdata : read data, valid in the mem_ack cycle
//   mem_ack   : one-cycle completion pulse from the memory
// Modports: master (arbiter side), slave (memory side).
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/mem_port_arbiter_timer.sv
// arb_wait_timer: counts the cycles an access has been waiting for mem_ack.
//   clk     : clock
//   rst     : synchronous active-high reset
//   run     : high while an access is outstanding; low clears the count
//   expired : high in the last allowed wait cycle (count == TIMEOUT-1)
// The count is zero in the first outstanding cycle, so expired marks the
// TIMEOUT-th cycle of waiting; an ack in that same cycle still wins.
module arb_wait_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_r;

    // Wait counter: advances while an access is outstanding, zero otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (run) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= '0;
        end
    end

    assign expired = run & (count_r == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// (IF stage) and loads/stores (MEM stage) and produces the pipeline stalls.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   if_req/if_addr            : fetch request (level) and PC
//   if_rdata/if_done          : fetched instruction, one-cycle done pulse
//   d_read/d_write            : load/store request (level); both = store
//   d_addr/d_wdata            : data address and store data
//   d_rdata/d_done            : load data, one-cycle done pulse
//   stall_if/stall_mem        : combinational pipeline freeze signals
//   mem                       : memory bus (mem_port_arbiter_if.master)
//   timeout_err               : sticky "memory never acknowledged" flag
// Optional build macro MEM_ARB_PERF_EN adds perf_if_stall/perf_mem_stall,
// saturating counts of cycles with stall_if / stall_mem high.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [AW-1:0]        if_addr,
    output logic [DW-1:0]        if_rdata,
    output logic                 if_done,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [AW-1:0]        d_addr,
    input  logic [DW-1:0]        d_wdata,
    output logic [DW-1:0]        d_rdata,
    output logic                 d_done,
    output logic                 stall_if,
    output logic                 stall_mem,
    mem_port_arbiter_if.master   mem,
    output logic                 timeout_err
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]          perf_if_stall,
    output logic [31:0]          perf_mem_stall
`endif
);

    arb_state_t    state_r;
    arb_state_t    state_s;
    logic          mem_req_r;
    logic          mem_req_s;
    logic          mem_we_r;
    logic          mem_we_s;
    logic [AW-1:0] mem_addr_r;
    logic [AW-1:0] mem_addr_s;
    logic [DW-1:0] mem_wdata_r;
    logic [DW-1:0] mem_wdata_s;
    logic [DW-1:0] if_rdata_r;
    logic [DW-1:0] if_rdata_s;
    logic [DW-1:0] d_rdata_r;
    logic [DW-1:0] d_rdata_s;
    logic          if_done_r;
    logic          if_done_s;
    logic          d_done_r;
    logic          d_done_s;
    logic          timeout_err_r;
    logic          timeout_err_s;
    logic          busy_s;
    logic          expired_s;
    logic          d_pending_s;
    logic          if_pending_s;

    // A requester whose done pulse is showing this cycle is finished: its
    // request line still belongs to the completed instruction and advances
    // at this edge, so it must neither stall nor be issued a second time.
    assign d_pending_s  = (d_read | d_write) & ~d_done_r;
    assign if_pending_s = if_req & ~if_done_r;

    // A pending data access freezes fetch too: the older instruction wins.
    assign stall_mem = d_pending_s;
    assign stall_if  = d_pending_s | if_pending_s;

    assign busy_s = (state_r == DATA) | (state_r == FETCH);

    arb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (busy_s),
        .expired (expired_s)
    );

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_s       = state_r;
        mem_req_s     = mem_req_r;
        mem_we_s      = mem_we_r;
        mem_addr_s    = mem_addr_r;
        mem_wdata_s   = mem_wdata_r;
        if_rdata_s    = if_rdata_r;
        d_rdata_s     = d_rdata_r;
        if_done_s     = 1'b0;
        d_done_s      = 1'b0;
        timeout_err_s = timeout_err_r;

        case (state_r)
            IDLE: begin
                // mem_ack is deliberately not looked at here.
                if (d_pending_s) begin
                    state_s     = DATA;
                    mem_req_s   = 1'b1;
                    mem_we_s    = d_write;
                    mem_addr_s  = d_addr;
                    mem_wdata_s = d_wdata;
                end else if (if_pending_s) begin
                    state_s    = FETCH;
                    mem_req_s  = 1'b1;
                    mem_we_s   = 1'b0;
                    mem_addr_s = if_addr;
                end else begin
                    state_s = IDLE;
                end
            end

            DATA, FETCH: begin
                // An ack in the final allowed wait cycle still completes.
                if (mem.mem_ack) begin
                    state_s   = IDLE;
                    mem_req_s = 1'b0;
                    if (state_r == DATA) begin
                        d_rdata_s = mem.mem_rdata;
                        d_done_s  = 1'b1;
                    end else begin
                        if_rdata_s = mem.mem_rdata;
                        if_done_s  = 1'b1;
                    end
                end else if (expired_s) begin
                    state_s       = IDLE;
                    mem_req_s     = 1'b0;
                    timeout_err_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end

            default: begin
                state_s   = IDLE;
                mem_req_s = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= '0;
            mem_wdata_r   <= '0;
            if_rdata_r    <= '0;
            d_rdata_r     <= '0;
            if_done_r     <= 1'b0;
            d_done_r      <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            mem_req_r     <= mem_req_s;
            mem_we_r      <= mem_we_s;
            mem_addr_r    <= mem_addr_s;
            mem_wdata_r   <= mem_wdata_s;
            if_rdata_r    <= if_rdata_s;
            d_rdata_r     <= d_rdata_s;
            if_done_r     <= if_done_s;
            d_done_r      <= d_done_s;
            timeout_err_r <= timeout_err_s;
        end
    end

    assign mem.mem_req   = mem_req_r;
    assign mem.mem_we    = mem_we_r;
    assign mem.mem_addr  = mem_addr_r;
    assign mem.mem_wdata = mem_wdata_r;
    assign if_rdata      = if_rdata_r;
    assign d_rdata       = d_rdata_r;
    assign if_done       = if_done_r;
    assign d_done        = d_done_r;
    assign timeout_err   = timeout_err_r;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_stall_r;
    logic [31:0] perf_mem_stall_r;

    // Saturating stall-cycle counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_stall_r  <= 32'd0;
            perf_mem_stall_r <= 32'd0;
        end else begin
            if (stall_if) begin
                perf_if_stall_r <= sat_inc32(perf_if_stall_r);
            end else begin
                perf_if_stall_r <= perf_if_stall_r;
            end
            if (stall_mem) begin
                perf_mem_stall_r <= sat_inc32(perf_mem_stall_r);
            end else begin
                perf_mem_stall_r <= perf_mem_stall_r;
            end
        end
    end

    assign perf_if_stall  = perf_if_stall_r;
    assign perf_mem_stall = perf_mem_stall_r;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized
// requesters and a randomized-latency memory, all compared each cycle with a
// transaction-level reference model of the arbiter.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          stall_if;
    logic          stall_mem;
    logic          timeout_err;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]   perf_if_stall;
    logic [31:0]   perf_mem_stall;
`endif

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) mem_bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_done     (if_done),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_done      (d_done),
        .stall_if    (stall_if),
        .stall_mem   (stall_mem),
        .mem         (mem_bus),
        .timeout_err (timeout_err)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_stall  (perf_if_stall),
        .perf_mem_stall (perf_mem_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the memory (0 none, 1 data, 2 fetch) and
    // the values the arbiter should present.
    int          m_owner;
    int          m_wait;
    logic        m_req;
    logic        m_req_prev;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_if_rdata;
    logic [31:0] m_d_rdata;
    logic        m_if_done;
    logic        m_d_done;
    logic        m_err;
    logic [31:0] m_perf_if;
    logic [31:0] m_perf_mem;

    // Memory responder and random requesters.
    int force_lat = -1;
    bit spur_en   = 1'b0;
    bit rsp_busy  = 1'b0;
    int rsp_cnt   = 0;
    int rsp_lat   = 0;
    bit d_act = 1'b0, d_rel = 1'b0, f_act = 1'b0, f_rel = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit exp_stall_mem();
        return (d_read || d_write) && !m_d_done;
    endfunction

    function automatic bit exp_stall_if();
        return exp_stall_mem() || (if_req && !m_if_done);
    endfunction

    // Apply one clock edge to the model using the inputs present before it.
    task automatic model_edge();
        logic was_d_done, was_if_done;
        if (rst) begin
            m_owner = 0; m_wait = 0; m_req = 1'b0; m_we = 1'b0;
            m_addr = 32'd0; m_wdata = 32'd0; m_if_rdata = 32'd0; m_d_rdata = 32'd0;
            m_if_done = 1'b0; m_d_done = 1'b0; m_err = 1'b0;
            m_perf_if = 32'd0; m_perf_mem = 32'd0;
        end else begin
            if (exp_stall_if() && m_perf_if != 32'hFFFF_FFFF) m_perf_if++;
            if (exp_stall_mem() && m_perf_mem != 32'hFFFF_FFFF) m_perf_mem++;
            was_d_done  = m_d_done;
            was_if_done = m_if_done;
            m_d_done  = 1'b0;
            m_if_done = 1'b0;
            if (m_owner == 0) begin
                if ((d_read || d_write) && !was_d_done) begin
                    m_owner = 1; m_wait = 0; m_req = 1'b1;
                    m_we = d_write; m_addr = d_addr; m_wdata = d_wdata;
                end else if (if_req && !was_if_done) begin
                    m_owner = 2; m_wait = 0; m_req = 1'b1;
                    m_we = 1'b0; m_addr = if_addr;
                end
            end else if (mem_bus.mem_ack) begin
                if (m_owner == 1) begin
                    m_d_rdata = mem_bus.mem_rdata; m_d_done = 1'b1;
                end else begin
                    m_if_rdata = mem_bus.mem_rdata; m_if_done = 1'b1;
                end
                m_owner = 0; m_req = 1'b0;
            end else if (m_wait + 1 >= TMO) begin
                m_err = 1'b1; m_req = 1'b0; m_owner = 0;
            end else begin
                m_wait++;
            end
        end
    endtask

    // Memory: acknowledges each new request after a chosen latency; a
    // latency of TMO or more never arrives in time.
    task automatic responder();
        int r;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = $urandom;
        if (m_req && !m_req_prev) begin
            rsp_busy = 1'b1;
            rsp_cnt  = 0;
            if (force_lat >= 0) begin
                rsp_lat = force_lat;
            end else begin
                r = $urandom_range(0, 9);
                rsp_lat = (r < 8) ? (r % 4) : ((r == 8) ? 4 : 6);
            end
        end
        if (rsp_busy) begin
            if (rsp_cnt == rsp_lat) begin
                mem_bus.mem_ack = 1'b1;
                rsp_busy = 1'b0;
            end else begin
                rsp_cnt++;
            end
        end else if (spur_en && !m_req && $urandom_range(0, 9) == 0) begin
            mem_bus.mem_ack = 1'b1;
        end
    endtask

    // One clock cycle: drive memory, compare outputs, advance the model.
    task automatic step();
        responder();
        #1;
        check_eq("stall_if",  stall_if,  exp_stall_if());
        check_eq("stall_mem", stall_mem, exp_stall_mem());
        check_eq("mem_req",   mem_bus.mem_req,   m_req);
        check_eq("mem_we",    mem_bus.mem_we,    m_we);
        check_eq("mem_addr",  mem_bus.mem_addr,  m_addr);
        check_eq("mem_wdata", mem_bus.mem_wdata, m_wdata);
        check_eq("if_done",   if_done,   m_if_done);
        check_eq("d_done",    d_done,    m_d_done);
        check_eq("if_rdata",  if_rdata,  m_if_rdata);
        check_eq("d_rdata",   d_rdata,   m_d_rdata);
        check_eq("timeout_err", timeout_err, m_err);
`ifdef MEM_ARB_PERF_EN
        check_eq("perf_if_stall",  perf_if_stall,  m_perf_if);
        check_eq("perf_mem_stall", perf_mem_stall, m_perf_mem);
`endif
        m_req_prev = m_req;
        @(posedge clk);
        #1;
        model_edge();
    endtask

    // Step until the model shows a done pulse (1 data, 2 fetch), bounded.
    task automatic wait_done(input int which, input int budget);
        int n = 0;
        while (!((which == 1) ? m_d_done : m_if_done) && n < budget) begin
            step();
            n++;
        end
        check_eq((which == 1) ? "d_done_seen" : "if_done_seen",
                 (which == 1) ? d_done : if_done, 1'b1);
    endtask

    task automatic drive_random();
        rst = ($urandom_range(0, 299) == 0);
        if (d_rel) begin
            d_act = 1'b0; d_rel = 1'b0; d_read = 1'b0; d_write = 1'b0;
        end
        if (d_act && m_d_done) begin
            d_rel = 1'b1;
        end else if (d_act && $urandom_range(0, 49) == 0) begin
            d_act = 1'b0; d_read = 1'b0; d_write = 1'b0;
        end
        if (!d_act && m_owner != 1 && !m_d_done && $urandom_range(0, 3) == 0) begin
            int k = $urandom_range(0, 3);
            d_act   = 1'b1;
            d_read  = (k != 1);
            d_write = (k == 1) || (k == 2);
            d_addr  = $urandom;
            d_wdata = $urandom;
        end
        if (f_rel) begin
            f_act = 1'b0; f_rel = 1'b0; if_req = 1'b0;
        end
        if (f_act && m_if_done) begin
            f_rel = 1'b1;
        end else if (f_act && $urandom_range(0, 49) == 0) begin
            f_act = 1'b0; if_req = 1'b0;
        end
        if (!f_act && m_owner != 2 && !m_if_done && $urandom_range(0, 2) == 0) begin
            f_act   = 1'b1;
            if_req  = 1'b1;
            if_addr = $urandom;
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_read = 1'b0; d_write = 1'b0;
        d_addr = '0; d_wdata = '0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
        m_req = 1'b0; m_req_prev = 1'b0;
        @(posedge clk);
        #1;
        model_edge();
        step();
        step();
        rst = 1'b0;
        step();

        // Fetch only, ack three cycles after mem_req.
        if_req = 1'b1; if_addr = 32'h40; force_lat = 3;
        step();
        check_eq("fetch_addr", mem_bus.mem_addr, 32'h40);
        check_eq("fetch_we", mem_bus.mem_we, 1'b0);
        wait_done(2, 20);
        step();
        if_req = 1'b0;
        step();

        // Store.
        d_write = 1'b1; d_addr = 32'h8; d_wdata = 32'hDEAD_BEEF; force_lat = 2;
        step();
        check_eq("store_we", mem_bus.mem_we, 1'b1);
        check_eq("store_wdata", mem_bus.mem_wdata, 32'hDEAD_BEEF);
        step();
        check_eq("store_wdata_hold", mem_bus.mem_wdata, 32'hDEAD_BEEF);
        wait_done(1, 20);
        step();
        d_write = 1'b0;
        step();

        // Simultaneous fetch and load: data first, then fetch.
        if_req = 1'b1; if_addr = 32'h80; d_read = 1'b1; d_addr = 32'h100; force_lat = 1;
        step();
        check_eq("simul_data_first", mem_bus.mem_addr, 32'h100);
        wait_done(1, 20);
        step();
        d_read = 1'b0;
        check_eq("simul_then_fetch", mem_bus.mem_addr, 32'h80);
        wait_done(2, 20);
        step();
        if_req = 1'b0;
        step();

        // Fetch in flight, then a load arrives: fetch completes first.
        if_req = 1'b1; if_addr = 32'hC0; force_lat = 3;
        step();
        step();
        d_read = 1'b1; d_addr = 32'h140;
        wait_done(2, 20);
        step();
        if_req = 1'b0;
        check_eq("after_fetch_data_addr", mem_bus.mem_addr, 32'h140);
        check_eq("after_fetch_data_req", mem_bus.mem_req, 1'b1);
        wait_done(1, 20);
        step();
        d_read = 1'b0;
        step();

        // No ack: timeout, sticky error, next request still served.
        d_read = 1'b1; d_addr = 32'h20; force_lat = 50;
        step();
        for (int i = 0; i < 20 && !m_err; i++) step();
        check_eq("timeout_set", timeout_err, 1'b1);
        check_eq("timeout_req_drop", mem_bus.mem_req, 1'b0);
        force_lat = 1;
        wait_done(1, 20);
        check_eq("timeout_sticky", timeout_err, 1'b1);
        step();
        d_read = 1'b0;
        step();

        // Reset during DATA; the late ack must be ignored.
        d_read = 1'b1; d_addr = 32'h60; force_lat = 3;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; d_read = 1'b0;
        check_eq("rst_req", mem_bus.mem_req, 1'b0);
        check_eq("rst_err", timeout_err, 1'b0);
        for (int i = 0; i < 5; i++) step();

        // Randomized traffic.
        force_lat = -1; spur_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the IF stage (fetch, read-only) and the MEM stage (lw/sw).
- Sequences each access through a request/acknowledge handshake with the memory.
- Generates the stall signals that freeze PC, IF/ID and the downstream pipeline registers while a requester waits.
- Sits between the pipeline datapath and the memory model, alongside the hazard unit.

Parameters:
- AW, 32, address width in bits
- DW, 32, data width in bits
- TIMEOUT, 16, max cycles to wait for mem_ack before flagging an error; must be ≥ 2

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- if_req  input  1  fetch request, level, held until if_done
- if_addr  input  AW  fetch address (PC)
- if_rdata  output  DW  fetched instruction, valid when if_done=1
- if_done  output  1  one-cycle pulse, fetch complete
- d_read  input  1  MEM-stage load request (Memread), level
- d_write  input  1  MEM-stage store request (Memwrite), level
- d_addr  input  AW  data address (ALU result)
- d_wdata  input  DW  store data
- d_rdata  output  DW  load data, valid when d_done=1
- d_done  output  1  one-cycle pulse, data access complete
- stall_if  output  1  freeze PC and IF/ID (combinational)
- stall_mem  output  1  freeze ID/EX, EX/MEM, MEM/WB (combinational)
- mem_req  output  1  memory request, held until mem_ack
- mem_we  output  1  write enable, qualified by mem_req
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data, valid with mem_ack
- mem_ack  input  1  one-cycle completion pulse from memory
- timeout_err  output  1  sticky error flag

Behaviour:
- States: IDLE, DATA, FETCH.
- Reset values: state=IDLE; mem_req, mem_we, if_done, d_done, timeout_err = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0; wait counter = 0.
- IDLE:
  - if d_read|d_write: latch d_addr/d_wdata/we=d_write into mem_* regs, mem_req=1 next cycle, go to DATA.
  - else if if_req: latch if_addr, we=0, go to FETCH.
  - Data has fixed priority over fetch, because it belongs to the older instruction.
- DATA/FETCH:
  - mem_* outputs are registered and held stable until mem_ack.
  - On mem_ack: capture mem_rdata into d_rdata/if_rdata, pulse d_done/if_done for exactly one cycle, drop mem_req, return to IDLE.
  - Minimum access = 2 cycles (issue + ack); back-to-back accesses re-arbitrate in IDLE.
- d_read and d_write both high: treated as a write.
- stall_mem = (d_read|d_write) & ~d_done.
- stall_if = stall_mem | (if_req & ~if_done).
  - A pending data access therefore also stalls fetch.
  - A fetch in flight when the MEM stage requests is finished first (no abort), then the data access is served.
- Requester deasserting its request mid-access: the access still completes; the done pulse is still issued.
- mem_ack while IDLE: ignored.
- Timeout: wait counter increments each cycle in DATA/FETCH and clears on entry.
  - Reaching TIMEOUT with no ack: set timeout_err (sticky until rst), drop mem_req, return to IDLE, no done pulse.
- rst mid-access: immediate return to IDLE; mem_req drops in the same edge; any pending ack is discarded.
- if_rdata/d_rdata hold their last value between accesses.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- When defined: adds outputs perf_if_stall[31:0] and perf_mem_stall[31:0].
  - Saturating counters of cycles with stall_if=1 and stall_mem=1 respectively.
  - Cleared by rst.
- When undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package mem_arb_pkg: state encoding typedef (IDLE=2'd0, DATA=2'd1, FETCH=2'd2), default AW/DW constants.
- One natural sub-module: arb_wait_timer (wait counter plus timeout compare).

Test Plan:
- Fetch only: if_req=1, if_addr=0x40, mem_ack 3 cycles after mem_req → mem_addr=0x40, mem_we=0, if_done pulses once, if_rdata=mem_rdata, stall_if high until the done cycle.
- Simultaneous: if_req=1 and d_read=1 with d_addr=0x100 in the same cycle → data served first (mem_addr=0x100), then fetch; stall_if stays high throughout.
- Store: d_write=1, d_addr=0x8, d_wdata=0xDEADBEEF → mem_we=1, mem_wdata=0xDEADBEEF stable until ack; d_done single pulse.
- Fetch in flight, then d_read asserts → fetch completes first (if_done), then data access; no mem_req glitch between accesses.
- No ack with TIMEOUT=4 → mem_req drops after 4 wait cycles, timeout_err=1 and stays 1; next request is still served.
- rst asserted during DATA → next cycle state=IDLE, all outputs at reset values; a late mem_ack produces no done pulse.
